// File: rtl/keypad_scanner.sv
// Matrix keypad scanner: strobes active-low columns, debounces one key at a time
// in tick units and queues press/release/repeat events for a valid/ready consumer.
module keypad_scanner #(
  parameter int ROWS        = 4,
  parameter int COLS        = 4,
  parameter int TICK_DIV    = 50000,
  parameter int DEBOUNCE    = 20,
  parameter int REPEAT_DLY  = 500,
  parameter int REPEAT_RATE = 100,
  parameter int FIFO_DEPTH  = 4,
  localparam int CODE_W     = $clog2(ROWS*COLS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ROWS-1:0]   row_in,
  output logic [COLS-1:0]   col_out,
  input  logic              rep_en,
  input  logic              ovf_clr,
  output logic [CODE_W-1:0] key_code,
  output logic              key_press,
  output logic              key_valid,
  input  logic              key_ready,
  output logic              held,
  output logic              overflow,
  output logic              multi
);

  localparam int TICK_W  = $clog2(TICK_DIV + 1);
  localparam int ROW_W   = $clog2(ROWS);
  localparam int COL_W   = $clog2(COLS);
  localparam int DEB_W   = $clog2(DEBOUNCE + 1);
  localparam int RPT_MAX = (REPEAT_DLY > REPEAT_RATE) ? REPEAT_DLY : REPEAT_RATE;
  localparam int RPT_W   = $clog2(RPT_MAX + 1);
  localparam int PTR_W   = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {ST_IDLE, ST_SCAN, ST_DEB, ST_PRESSED} state_t;

  state_t state_reg, state_next;

  logic [ROWS-1:0]   rs_meta, rs;
  logic [TICK_W-1:0] tick_cnt;
  logic              tick;

  logic [COL_W-1:0]  col_reg;
  logic [ROW_W-1:0]  row_reg;
  logic [DEB_W-1:0]  deb_cnt, rel_cnt;
  logic [RPT_W-1:0]  rep_cnt;
  logic              rep_phase;

  logic [ROWS-1:0]   low;
  logic              any_low, one_low, match;
  logic [ROW_W-1:0]  low_idx;
  logic [DEB_W-1:0]  deb_inc, rel_inc;
  logic [RPT_W-1:0]  rep_inc;
  logic              deb_done, rel_done, rep_hit;

  logic              push, push_press;
  logic [ROW_W-1:0]  push_row;
  logic [CODE_W-1:0] push_code;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rs_meta <= '1;
      rs      <= '1;
    end else begin
      rs_meta <= row_in;
      rs      <= rs_meta;
    end
  end

  assign tick = (tick_cnt == TICK_W'(TICK_DIV - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) tick_cnt <= '0;
    else        tick_cnt <= tick ? '0 : tick_cnt + TICK_W'(1);
  end

  // Row sample classification: none, exactly one, or several rows pulled low.
  assign low     = ~rs;
  assign any_low = |low;
  assign one_low = any_low && ((low & (low - ROWS'(1))) == '0);
  assign match   = (rs == ~(ROWS'(1) << row_reg));

  always_comb begin
    low_idx = '0;
    for (int r = 0; r < ROWS; r++)
      if (low[r]) low_idx = ROW_W'(r);
  end

  assign deb_inc  = deb_cnt + DEB_W'(1);
  assign deb_done = (deb_inc >= DEB_W'(DEBOUNCE));
  assign rel_inc  = (&rs) ? rel_cnt + DEB_W'(1) : '0;
  assign rel_done = (rel_inc == DEB_W'(DEBOUNCE));
  assign rep_inc  = rep_cnt + RPT_W'(1);
  assign rep_hit  = rep_en && (rep_inc == (rep_phase ? RPT_W'(REPEAT_RATE) : RPT_W'(REPEAT_DLY)));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_reg <= ST_IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    if (tick) begin
      unique case (state_reg)
        ST_IDLE: if (any_low) state_next = ST_SCAN;
        ST_SCAN: begin
          if (one_low)                            state_next = (DEBOUNCE == 1) ? ST_PRESSED : ST_DEB;
          else if (any_low)                       state_next = ST_IDLE;
          else if (col_reg == COL_W'(COLS - 1))   state_next = ST_IDLE;
        end
        ST_DEB: begin
          if (!match)        state_next = ST_IDLE;
          else if (deb_done) state_next = ST_PRESSED;
        end
        ST_PRESSED: if (rel_done) state_next = ST_IDLE;
        default: state_next = ST_IDLE;
      endcase
    end
  end

  // Event requests; a release takes priority over a coincident repeat.
  always_comb begin
    push       = 1'b0;
    push_press = 1'b0;
    if (tick) begin
      unique case (state_reg)
        ST_SCAN: if (one_low && DEBOUNCE == 1) begin
          push       = 1'b1;
          push_press = 1'b1;
        end
        ST_DEB: if (match && deb_done) begin
          push       = 1'b1;
          push_press = 1'b1;
        end
        ST_PRESSED: begin
          if (rel_done) begin
            push = 1'b1;
          end else if (rep_hit) begin
            push       = 1'b1;
            push_press = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  for (genvar gi = 0; gi < COLS; gi++) begin : g_col
    assign col_out[gi] = (state_reg != ST_IDLE) && (col_reg != COL_W'(gi));
  end

  assign push_row  = (state_reg == ST_SCAN) ? low_idx : row_reg;
  assign push_code = CODE_W'(int'(push_row) * COLS + int'(col_reg));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      col_reg   <= '0;
      row_reg   <= '0;
      deb_cnt   <= '0;
      rel_cnt   <= '0;
      rep_cnt   <= '0;
      rep_phase <= 1'b0;
      held      <= 1'b0;
      multi     <= 1'b0;
    end else begin
      multi <= 1'b0;
      if (tick) begin
        unique case (state_reg)
          ST_IDLE: col_reg <= '0;
          ST_SCAN: begin
            if (one_low) begin
              row_reg   <= low_idx;
              deb_cnt   <= DEB_W'(1);
              rel_cnt   <= '0;
              rep_cnt   <= '0;
              rep_phase <= 1'b0;
              if (DEBOUNCE == 1) held <= 1'b1;
            end else if (any_low) begin
              multi <= 1'b1;
            end else if (col_reg != COL_W'(COLS - 1)) begin
              col_reg <= col_reg + COL_W'(1);
            end
          end
          ST_DEB: begin
            if (match) begin
              deb_cnt <= deb_inc;
              if (deb_done) begin
                held      <= 1'b1;
                rel_cnt   <= '0;
                rep_cnt   <= '0;
                rep_phase <= 1'b0;
              end
            end
          end
          ST_PRESSED: begin
            rel_cnt <= rel_inc;
            if (rel_done) held <= 1'b0;
            // First repeat waits REPEAT_DLY, later ones REPEAT_RATE.
            if (!rep_en) begin
              rep_cnt   <= '0;
              rep_phase <= 1'b0;
            end else if (rep_hit) begin
              rep_cnt   <= '0;
              rep_phase <= 1'b1;
            end else begin
              rep_cnt <= rep_inc;
            end
          end
          default: ;
        endcase
      end
    end
  end

  logic [CODE_W:0] fifo_mem [FIFO_DEPTH];
  logic [PTR_W:0]  wr_ptr, rd_ptr;
  logic            fifo_full, fifo_empty, fifo_wr, fifo_rd, fifo_drop;
  logic [CODE_W:0] head;

  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                      (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
  assign key_valid  = !fifo_empty;
  assign fifo_rd    = key_valid && key_ready;
  // A read in the same clk frees a slot, so a push into a full queue still lands.
  assign fifo_wr    = push && (!fifo_full || fifo_rd);
  assign fifo_drop  = push && fifo_full && !fifo_rd;

  always_ff @(posedge clk) begin
    if (fifo_wr) fifo_mem[wr_ptr[PTR_W-1:0]] <= {push_code, push_press};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      overflow <= 1'b0;
    end else begin
      if (fifo_wr) wr_ptr <= wr_ptr + (PTR_W+1)'(1);
      if (fifo_rd) rd_ptr <= rd_ptr + (PTR_W+1)'(1);
      if (fifo_drop)    overflow <= 1'b1;
      else if (ovf_clr) overflow <= 1'b0;
    end
  end

  assign head      = fifo_mem[rd_ptr[PTR_W-1:0]];
  assign key_code  = key_valid ? head[CODE_W:1] : '0;
  assign key_press = key_valid ? head[0] : 1'b0;

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner: a keypad model answers column strobes and a
// monitor logs every accepted event for comparison against hand-derived sequences.
module tb_keypad_scanner;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] row_in;
  logic [3:0] col_out;
  logic       rep_en;
  logic       ovf_clr;
  logic [3:0] key_code;
  logic       key_press;
  logic       key_valid;
  logic       key_ready;
  logic       held;
  logic       overflow;
  logic       multi;

  always #5 clk = ~clk;

  keypad_scanner #(
    .ROWS(4), .COLS(4), .TICK_DIV(4), .DEBOUNCE(3),
    .REPEAT_DLY(8), .REPEAT_RATE(4), .FIFO_DEPTH(4)
  ) dut (
    .clk(clk), .reset(reset), .row_in(row_in), .col_out(col_out),
    .rep_en(rep_en), .ovf_clr(ovf_clr), .key_code(key_code),
    .key_press(key_press), .key_valid(key_valid), .key_ready(key_ready),
    .held(held), .overflow(overflow), .multi(multi)
  );

  // key_down[r*4+c] closes the switch between row r and column c.
  logic [15:0] key_down;
  logic        use_rand;
  logic [3:0]  rand_rows;
  logic [3:0]  model_rows;

  always_comb begin
    model_rows = 4'b1111;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (key_down[r*4+c] && !col_out[c]) model_rows[r] = 1'b0;
  end

  assign row_in = use_rand ? rand_rows : model_rows;

  int         checks = 0;
  int         failures = 0;
  int         cyc = 0;
  logic [4:0] ev_q[$];
  int         ev_t[$];
  logic       ev_held[$];
  int         multi_cnt = 0;
  logic       multi_prev = 1'b0;
  logic       multi_long = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (reset && key_valid && key_ready) begin
      ev_q.push_back({key_code, key_press});
      ev_t.push_back(cyc);
      ev_held.push_back(held);
      $display("EV code=%0d press=%0d held=%0d cyc=%0d", key_code, key_press, held, cyc);
    end
    multi_prev <= multi;
    if (multi) multi_cnt <= multi_cnt + 1;
    if (multi && multi_prev) multi_long <= 1'b1;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic wait_held(input logic val, input string tag);
    int n = 0;
    while (held !== val && n < 500) begin
      @(negedge clk);
      n++;
    end
    check_eq(tag, 32'(held), 32'(val));
  endtask

  task automatic wait_col(input logic [3:0] val, input string tag);
    int n = 0;
    while (col_out !== val && n < 500) begin
      @(negedge clk);
      n++;
    end
    check_eq(tag, 32'(col_out), 32'(val));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int eb;
    int n;
    reset     = 1'b1;
    use_rand  = 1'b1;
    rand_rows = 4'hF;
    key_down  = '0;
    rep_en    = 1'b0;
    ovf_clr   = 1'b0;
    key_ready = 1'b1;
    #1 reset  = 1'b0;

    // Reset with random row activity.
    repeat (5) begin
      @(negedge clk);
      rand_rows = 4'($urandom);
    end
    check_eq("rst_col_out", 32'(col_out), 32'h0);
    check_eq("rst_key_code", 32'(key_code), 32'h0);
    check_eq("rst_key_press", 32'(key_press), 32'h0);
    check_eq("rst_key_valid", 32'(key_valid), 32'h0);
    check_eq("rst_held", 32'(held), 32'h0);
    check_eq("rst_overflow", 32'(overflow), 32'h0);
    check_eq("rst_multi", 32'(multi), 32'h0);
    use_rand = 1'b0;
    reset    = 1'b1;
    repeat (3) @(negedge clk);
    check_eq("idle_col_out", 32'(col_out), 32'h0);

    // Clean press/release of row1/col2 (code 6).
    eb = ev_q.size();
    key_down[6] = 1'b1;
    repeat (48) @(negedge clk);
    check_eq("clean_held_mid", 32'(held), 32'h1);
    key_down[6] = 1'b0;
    wait_held(1'b0, "clean_held_off");
    repeat (4) @(negedge clk);
    n = ev_q.size() - eb;
    check_eq("clean_count", 32'(n), 32'd2);
    if (n >= 2) begin
      check_eq("clean_ev0", 32'(ev_q[eb]), 32'h0D);
      check_eq("clean_ev1", 32'(ev_q[eb+1]), 32'h0C);
      check_eq("clean_held_at_press", 32'(ev_held[eb]), 32'h1);
      check_eq("clean_held_at_rel", 32'(ev_held[eb+1]), 32'h0);
    end

    // Bounce on row0/col0: released after capture + one debounce tick.
    eb = ev_q.size();
    key_down[0] = 1'b1;
    wait_col(4'b1110, "bounce_scan_col0");
    repeat (8) @(negedge clk);
    check_eq("bounce_deb_col", 32'(col_out), 32'b1110);
    key_down[0] = 1'b0;
    repeat (40) @(negedge clk);
    check_eq("bounce_no_event", 32'(ev_q.size() - eb), 32'd0);
    check_eq("bounce_held", 32'(held), 32'h0);
    check_eq("bounce_idle", 32'(col_out), 32'h0);

    // Auto-repeat on code 5, held 22 ticks past the press event.
    eb = ev_q.size();
    rep_en = 1'b1;
    key_down[5] = 1'b1;
    n = 0;
    while (ev_q.size() == eb && n < 500) begin
      @(negedge clk);
      n++;
    end
    check_eq("rep_first_seen", 32'(ev_q.size() - eb), 32'd1);
    repeat (88) @(negedge clk);
    key_down[5] = 1'b0;
    rep_en = 1'b0;
    wait_held(1'b0, "rep_held_off");
    repeat (4) @(negedge clk);
    n = ev_q.size() - eb;
    check_eq("rep_count", 32'(n), 32'd6);
    if (n >= 6) begin
      for (int i = 0; i < 5; i++) check_eq($sformatf("rep_ev%0d", i), 32'(ev_q[eb+i]), 32'h0B);
      check_eq("rep_release", 32'(ev_q[eb+5]), 32'h0A);
      check_eq("rep_gap_first", 32'(ev_t[eb+1] - ev_t[eb]), 32'd32);
      for (int i = 1; i < 4; i++)
        check_eq($sformatf("rep_gap%0d", i), 32'(ev_t[eb+i+1] - ev_t[eb+i]), 32'd16);
    end

    // Overflow: three press/release pairs with the consumer stalled.
    key_ready = 1'b0;
    eb = ev_q.size();
    for (int k = 0; k < 3; k++) begin
      int code;
      code = (k == 0) ? 9 : (k == 1) ? 15 : 3;
      key_down[code] = 1'b1;
      wait_held(1'b1, $sformatf("ovf_press%0d", k));
      key_down[code] = 1'b0;
      wait_held(1'b0, $sformatf("ovf_release%0d", k));
      repeat (8) @(negedge clk);
    end
    check_eq("ovf_valid", 32'(key_valid), 32'h1);
    check_eq("ovf_flag", 32'(overflow), 32'h1);
    check_eq("ovf_head_code", 32'(key_code), 32'd9);
    check_eq("ovf_head_press", 32'(key_press), 32'h1);
    key_ready = 1'b1;
    repeat (8) @(negedge clk);
    n = ev_q.size() - eb;
    check_eq("ovf_drain_count", 32'(n), 32'd4);
    if (n >= 4) begin
      check_eq("ovf_ev0", 32'(ev_q[eb]), 32'h13);
      check_eq("ovf_ev1", 32'(ev_q[eb+1]), 32'h12);
      check_eq("ovf_ev2", 32'(ev_q[eb+2]), 32'h1F);
      check_eq("ovf_ev3", 32'(ev_q[eb+3]), 32'h1E);
    end
    check_eq("ovf_empty_valid", 32'(key_valid), 32'h0);
    check_eq("ovf_empty_code", 32'(key_code), 32'h0);
    check_eq("ovf_sticky", 32'(overflow), 32'h1);
    ovf_clr = 1'b1;
    @(negedge clk);
    ovf_clr = 1'b0;
    check_eq("ovf_cleared", 32'(overflow), 32'h0);

    // Two rows low in col3.
    eb = ev_q.size();
    n = multi_cnt;
    key_down[3]  = 1'b1;
    key_down[11] = 1'b1;
    begin
      int w = 0;
      while (multi_cnt == n && w < 500) begin
        @(negedge clk);
        w++;
      end
    end
    check_eq("multi_seen", 32'(multi_cnt > n), 32'h1);
    key_down[3]  = 1'b0;
    key_down[11] = 1'b0;
    repeat (40) @(negedge clk);
    check_eq("multi_one_clk", 32'(multi_long), 32'h0);
    check_eq("multi_no_event", 32'(ev_q.size() - eb), 32'd0);
    check_eq("multi_held", 32'(held), 32'h0);

    // Queue events, then reset in the middle of debouncing code 4.
    key_ready = 1'b0;
    key_down[4] = 1'b1;
    wait_held(1'b1, "rst_mid_press");
    key_down[4] = 1'b0;
    wait_held(1'b0, "rst_mid_release");
    repeat (8) @(negedge clk);
    check_eq("rst_mid_queued", 32'(key_valid), 32'h1);
    key_down[4] = 1'b1;
    wait_col(4'b1110, "rst_mid_scan");
    repeat (8) @(negedge clk);
    check_eq("rst_mid_deb_col", 32'(col_out), 32'b1110);
    reset = 1'b0;
    #1;
    check_eq("rst_mid_col_out", 32'(col_out), 32'h0);
    check_eq("rst_mid_valid", 32'(key_valid), 32'h0);
    check_eq("rst_mid_held", 32'(held), 32'h0);
    repeat (3) @(negedge clk);
    key_down[4] = 1'b0;
    key_ready = 1'b1;
    eb = ev_q.size();
    reset = 1'b1;
    repeat (60) @(negedge clk);
    check_eq("rst_mid_no_event", 32'(ev_q.size() - eb), 32'd0);
    check_eq("rst_mid_still_empty", 32'(key_valid), 32'h0);
    check_eq("rst_mid_idle", 32'(col_out), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
